// File: rtl/gx_tx_sched.sv
// Transmit frame scheduler: round-robin between two requesters, emits
// SOF / payload / checksum / EOF bursts separated by K28.5 idle words.
module gx_tx_sched #(
    parameter logic [15:0] IDLE_WORD = 16'hBC50,
    parameter logic [7:0]  SOF_K     = 8'hFB,
    parameter logic [7:0]  EOF_K     = 8'hFD,
    parameter int unsigned IDLE_GAP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        link_up,
    input  logic        a0_req,
    input  logic [7:0]  a0_len,
    input  logic [15:0] a0_data,
    output logic        a0_rd,
    output logic        a0_done,
    input  logic        a1_req,
    input  logic [7:0]  a1_len,
    input  logic [15:0] a1_data,
    output logic        a1_rd,
    output logic        a1_done,
    output logic [15:0] tx_datain,
    output logic [1:0]  tx_ctrlenable,
    output logic        busy,
    output logic        grant_id,
    output logic        frame_abort
);

    localparam logic [3:0] GAP_MAX = 4'(IDLE_GAP);

    // The SOF word is launched by the arbitration edge itself, so the
    // state register tracks the word being fetched, not the word on the wire.
    typedef enum logic [1:0] {
        S_GAP  = 2'd0,
        S_DATA = 2'd1,
        S_CSUM = 2'd2,
        S_EOF  = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [3:0]  gap_r, gap_s;
    logic [7:0]  cnt_r, cnt_s;
    logic [15:0] csum_r, csum_s;
    logic        grant_r, grant_s;
    logic [15:0] tx_data_r, tx_data_s;
    logic [1:0]  tx_ctrl_r, tx_ctrl_s;
    logic        busy_r, busy_s;
    logic        done0_r, done0_s;
    logic        done1_r, done1_s;
    logic        abort_r, abort_s;

    logic        rd_s;
    logic        win_s;
    logic [7:0]  win_len_s;
    logic [15:0] sel_data_s;

    assign rd_s       = (state_r == S_DATA) && link_up;
    assign win_s      = (a0_req && a1_req) ? ~grant_r : (a0_req ? 1'b0 : 1'b1);
    assign win_len_s  = win_s ? a1_len : a0_len;
    assign sel_data_s = grant_r ? a1_data : a0_data;

    assign a0_rd         = rd_s && !grant_r;
    assign a1_rd         = rd_s && grant_r;
    assign a0_done       = done0_r;
    assign a1_done       = done1_r;
    assign tx_datain     = tx_data_r;
    assign tx_ctrlenable = tx_ctrl_r;
    assign busy          = busy_r;
    assign grant_id      = grant_r;
    assign frame_abort   = abort_r;

    // Next-state and next-output decode for the framing FSM.
    always_comb begin
        state_s   = state_r;
        gap_s     = gap_r;
        cnt_s     = cnt_r;
        csum_s    = csum_r;
        grant_s   = grant_r;
        tx_data_s = IDLE_WORD;
        tx_ctrl_s = 2'b10;
        busy_s    = busy_r;
        done0_s   = 1'b0;
        done1_s   = 1'b0;
        abort_s   = 1'b0;
        case (state_r)
            S_GAP: begin
                if (!link_up) begin
                    gap_s = 4'd0;
                end else if ((gap_r == GAP_MAX) && (a0_req || a1_req)) begin
                    grant_s   = win_s;
                    cnt_s     = win_len_s;
                    csum_s    = 16'd0;
                    tx_data_s = {SOF_K, win_len_s};
                    tx_ctrl_s = 2'b10;
                    busy_s    = 1'b1;
                    state_s   = S_DATA;
                end else if (gap_r != GAP_MAX) begin
                    gap_s = gap_r + 4'd1;
                end else begin
                    gap_s = gap_r;
                end
            end
            S_DATA: begin
                if (!link_up) begin
                    state_s = S_GAP;
                    gap_s   = 4'd0;
                    busy_s  = 1'b0;
                    abort_s = 1'b1;
                end else begin
                    tx_data_s = sel_data_s;
                    tx_ctrl_s = 2'b00;
                    csum_s    = csum_r + sel_data_s;
                    cnt_s     = cnt_r - 8'd1;
                    if (cnt_r == 8'd0) begin
                        state_s = S_CSUM;
                    end else begin
                        state_s = S_DATA;
                    end
                end
            end
            S_CSUM: begin
                if (!link_up) begin
                    state_s = S_GAP;
                    gap_s   = 4'd0;
                    busy_s  = 1'b0;
                    abort_s = 1'b1;
                end else begin
                    tx_data_s = csum_r;
                    tx_ctrl_s = 2'b00;
                    state_s   = S_EOF;
                end
            end
            S_EOF: begin
                if (!link_up) begin
                    state_s = S_GAP;
                    gap_s   = 4'd0;
                    busy_s  = 1'b0;
                    abort_s = 1'b1;
                end else begin
                    tx_data_s = {EOF_K, 8'h00};
                    tx_ctrl_s = 2'b10;
                    done0_s   = !grant_r;
                    done1_s   = grant_r;
                    busy_s    = 1'b0;
                    gap_s     = 4'd0;
                    state_s   = S_GAP;
                end
            end
            default: begin
                state_s = S_GAP;
                gap_s   = 4'd0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_GAP;
            gap_r     <= 4'd0;
            cnt_r     <= 8'd0;
            csum_r    <= 16'd0;
            grant_r   <= 1'b1;
            tx_data_r <= IDLE_WORD;
            tx_ctrl_r <= 2'b10;
            busy_r    <= 1'b0;
            done0_r   <= 1'b0;
            done1_r   <= 1'b0;
            abort_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            gap_r     <= gap_s;
            cnt_r     <= cnt_s;
            csum_r    <= csum_s;
            grant_r   <= grant_s;
            tx_data_r <= tx_data_s;
            tx_ctrl_r <= tx_ctrl_s;
            busy_r    <= busy_s;
            done0_r   <= done0_s;
            done1_r   <= done1_s;
            abort_r   <= abort_s;
        end
    end

endmodule

// File: tb/tb_gx_tx_sched.sv
// Directed bench for gx_tx_sched: framing, arbitration, link loss and reset.
module tb_gx_tx_sched;

    logic        clk;
    logic        rst;
    logic        link_up;
    logic        a0_req, a1_req;
    logic [7:0]  a0_len, a1_len;
    logic [15:0] a0_data, a1_data;
    logic        a0_rd, a1_rd, a0_done, a1_done;
    logic [15:0] tx_datain;
    logic [1:0]  tx_ctrlenable;
    logic        busy, grant_id, frame_abort;

    logic        clr;
    logic        a0_const;
    int          idx0, idx1, done0_n, done1_n, abort_n;
    int          total_cnt, bad_cnt;

    gx_tx_sched dut (
        .clk           (clk),
        .rst           (rst),
        .link_up       (link_up),
        .a0_req        (a0_req),
        .a0_len        (a0_len),
        .a0_data       (a0_data),
        .a0_rd         (a0_rd),
        .a0_done       (a0_done),
        .a1_req        (a1_req),
        .a1_len        (a1_len),
        .a1_data       (a1_data),
        .a1_rd         (a1_rd),
        .a1_done       (a1_done),
        .tx_datain     (tx_datain),
        .tx_ctrlenable (tx_ctrlenable),
        .busy          (busy),
        .grant_id      (grant_id),
        .frame_abort   (frame_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester sources: next word advances on each rd strobe.
    assign a0_data = a0_const ? 16'hFFFF : 16'(idx0 + 1);
    assign a1_data = 16'(32'h1000 + idx1 + 1);

    // Strobe and pulse counters seen at each clock edge.
    always @(posedge clk) begin
        if (clr) begin
            idx0 <= 0; idx1 <= 0; done0_n <= 0; done1_n <= 0; abort_n <= 0;
        end else begin
            if (a0_rd) idx0 <= idx0 + 1;
            if (a1_rd) idx1 <= idx1 + 1;
            if (a0_done) done0_n <= done0_n + 1;
            if (a1_done) done1_n <= done1_n + 1;
            if (frame_abort) abort_n <= abort_n + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1; clr = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic release_dut();
        rst = 1'b0; clr = 1'b0;
    endtask

    // Expects: 4 idles, SOF, len+1 payload words, checksum, EOF with done.
    task automatic run_frame(input string tag, input logic gid, input logic [7:0] len,
                             input logic [15:0] first, input logic [15:0] step,
                             input logic [15:0] csum_exp);
        int n;
        logic [15:0] w;
        n = 0;
        @(negedge clk);
        while (tx_datain == 16'hBC50 && n < 64) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_gap"}, n, 32'd4);
        check({tag, "_sof"}, tx_datain, {8'hFB, len});
        check({tag, "_sofk"}, tx_ctrlenable, 2'b10);
        check({tag, "_gnt"}, grant_id, gid);
        check({tag, "_busy"}, busy, 1'b1);
        check({tag, "_rd"}, gid ? a1_rd : a0_rd, 1'b1);
        w = first;
        for (int i = 0; i <= int'(len); i++) begin
            @(negedge clk);
            check({tag, "_dat"}, tx_datain, w);
            check({tag, "_datk"}, tx_ctrlenable, 2'b00);
            w = w + step;
        end
        @(negedge clk);
        check({tag, "_csum"}, tx_datain, csum_exp);
        check({tag, "_csumk"}, tx_ctrlenable, 2'b00);
        @(negedge clk);
        check({tag, "_eof"}, tx_datain, 16'hFD00);
        check({tag, "_eofk"}, tx_ctrlenable, 2'b10);
        check({tag, "_done0"}, a0_done, !gid);
        check({tag, "_done1"}, a1_done, gid);
        check({tag, "_busyeof"}, busy, 1'b0);
    endtask

    initial begin
        int cnt_idle, cnt_busy;
        total_cnt = 0; bad_cnt = 0;
        rst = 1'b1; clr = 1'b1; link_up = 1'b0; a0_const = 1'b0;
        a0_req = 1'b0; a1_req = 1'b0; a0_len = 8'd0; a1_len = 8'd0;

        // Reset values
        reset_dut();
        check("rst_tx", tx_datain, 16'hBC50);
        check("rst_k", tx_ctrlenable, 2'b10);
        check("rst_busy", busy, 1'b0);
        check("rst_gnt", grant_id, 1'b1);
        check("rst_rd", {a0_rd, a1_rd}, 2'b00);
        check("rst_pulse", {a0_done, a1_done, frame_abort}, 3'b000);

        // Single 4-word frame from requester 0
        a0_len = 8'd3; a0_req = 1'b1; link_up = 1'b1;
        release_dut();
        run_frame("f1", 1'b0, 8'd3, 16'h0001, 16'h0001, 16'h000A);
        a0_req = 1'b0;
        @(negedge clk);
        check("f1_donepulse", a0_done, 1'b0);
        check("f1_rdcnt", idx0, 32'd4);
        check("f1_donecnt", done0_n, 32'd1);

        // Maximum length frame, all-ones payload
        reset_dut();
        a0_len = 8'd255; a0_const = 1'b1; a0_req = 1'b1;
        release_dut();
        run_frame("max", 1'b0, 8'd255, 16'hFFFF, 16'h0000, 16'hFF00);
        a0_req = 1'b0;
        @(negedge clk);
        check("max_rdcnt", idx0, 32'd256);
        a0_const = 1'b0;

        // Back-to-back alternation with both pending
        reset_dut();
        a0_len = 8'd0; a1_len = 8'd0; a0_req = 1'b1; a1_req = 1'b1;
        release_dut();
        run_frame("b2b0", 1'b0, 8'd0, 16'h0001, 16'h0000, 16'h0001);
        run_frame("b2b1", 1'b1, 8'd0, 16'h1001, 16'h0000, 16'h1001);
        run_frame("b2b2", 1'b0, 8'd0, 16'h0002, 16'h0000, 16'h0002);
        run_frame("b2b3", 1'b1, 8'd0, 16'h1002, 16'h0000, 16'h1002);
        a0_req = 1'b0; a1_req = 1'b0;

        // Link loss on third payload cycle
        reset_dut();
        a0_len = 8'd5; a0_req = 1'b1;
        release_dut();
        repeat (5) @(negedge clk);
        check("ab_sof", tx_datain, 16'hFB05);
        repeat (2) @(negedge clk);
        link_up = 1'b0;
        #1;
        check("ab_rdlow", a0_rd, 1'b0);
        @(negedge clk);
        check("ab_idle", tx_datain, 16'hBC50);
        check("ab_idlek", tx_ctrlenable, 2'b10);
        check("ab_pulse", frame_abort, 1'b1);
        check("ab_busy", busy, 1'b0);
        check("ab_nodone", a0_done, 1'b0);
        @(negedge clk);
        check("ab_pulse1", frame_abort, 1'b0);
        cnt_idle = 0;
        repeat (6) begin
            @(negedge clk);
            if (tx_datain == 16'hBC50 && !a0_rd) cnt_idle++;
        end
        check("ab_linkdown", cnt_idle, 32'd6);
        check("ab_rdcnt", idx0, 32'd2);
        check("ab_abcnt", abort_n, 32'd1);
        link_up = 1'b1;
        run_frame("ab_re", 1'b0, 8'd5, 16'h0003, 16'h0001, 16'h0021);
        a0_req = 1'b0;
        @(negedge clk);
        check("ab_donecnt", done0_n, 32'd1);

        // Reset in the middle of a frame, then a tie
        reset_dut();
        a1_len = 8'd7; a1_req = 1'b1;
        release_dut();
        repeat (5) @(negedge clk);
        check("mr_sof", tx_datain, 16'hFB07);
        check("mr_gnt1", grant_id, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1; clr = 1'b1;
        @(negedge clk);
        check("mr_tx", tx_datain, 16'hBC50);
        check("mr_k", tx_ctrlenable, 2'b10);
        check("mr_busy", busy, 1'b0);
        check("mr_rd", {a0_rd, a1_rd}, 2'b00);
        check("mr_gnt", grant_id, 1'b1);
        check("mr_pulse", {a1_done, frame_abort}, 2'b00);
        a0_len = 8'd0; a0_req = 1'b1;
        release_dut();
        run_frame("mr_tie", 1'b0, 8'd0, 16'h0001, 16'h0000, 16'h0001);
        a0_req = 1'b0; a1_req = 1'b0;

        // Link down with a pending request: idle forever
        reset_dut();
        link_up = 1'b0; a1_req = 1'b1; a1_len = 8'd2;
        release_dut();
        cnt_idle = 0; cnt_busy = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx_datain == 16'hBC50 && tx_ctrlenable == 2'b10) cnt_idle++;
            if (busy) cnt_busy++;
        end
        check("ld_idle", cnt_idle, 32'd30);
        check("ld_busy", cnt_busy, 32'd0);
        check("ld_rdcnt", idx1, 32'd0);
        a1_req = 1'b0;

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
